// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Front-panel program loader for the 8-bit enhanced processor.
//               Writer side of the 32x8 program RAM: takes one switch byte
//               per Enter press, writes it to consecutive addresses, pads the
//               remaining locations with FILL_VALUE, then releases the CPU.
//               Holds the processor in reset (CpuHold) and owns the RAM port
//               (RamInit) for the whole session.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clock      in   1         system clock, rising edge
//   Reset      in   1         asynchronous, active-low reset
//   Start      in   1         one-cycle request to begin a load session
//   Enter      in   1         debounced push-button level, async to Clock
//   Input      in   DATA_W    switch data, stable while Enter is high
//   Finish     in   1         one-cycle request to end user entry early
//   RamOut     in   DATA_W    RAM read data, valid one cycle after address
//   RamInit    out  1         RAM port owned by the loader
//   RamAddress out  ADDR_W    RAM address
//   RamIn      out  DATA_W    RAM write data
//   RamWr      out  1         RAM write strobe, one cycle per word
//   CpuHold    out  1         keeps the processor in reset
//   Busy       out  1         session in progress
//   Done       out  1         load complete, CPU released
//   Error      out  1         verify mismatch (0 without verify build)
//   Count      out  ADDR_W+1  number of user bytes written, 0..DEPTH
//   state      out  3         current FSM state, for display
// ----------------------------------------------------------------------------
// Build option
//   PROGRAM_LOADER_VERIFY_EN : adds a read-back VERIFY pass that compares a
//                              modulo-2^DATA_W checksum of every written word
//                              with the sum of the RAM contents.
// ============================================================================
module program_loader #(
    parameter int                ADDR_W     = 5,
    parameter int                DEPTH      = 32,
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] FILL_VALUE = 8'hE0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Enter,
    input  logic [DATA_W-1:0] Input,
    input  logic              Finish,
    input  logic [DATA_W-1:0] RamOut,
    output logic              RamInit,
    output logic [ADDR_W-1:0] RamAddress,
    output logic [DATA_W-1:0] RamIn,
    output logic              RamWr,
    output logic              CpuHold,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [ADDR_W:0]   Count,
    output logic [2:0]        state
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_LOAD   = 3'd1;
    localparam logic [2:0] c_S_WRITE  = 3'd2;
    localparam logic [2:0] c_S_FILL   = 3'd3;
`ifdef PROGRAM_LOADER_VERIFY_EN
    localparam logic [2:0] c_S_VERIFY = 3'd4;
`endif
    localparam logic [2:0] c_S_DONE   = 3'd5;

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_FULL = (ADDR_W + 1)'(DEPTH);

    logic [2:0]        r_state;
    logic              r_s1;
    logic              r_s2;
    logic              r_d;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_fin;
    logic              r_busy;
    logic              r_wr;
    logic              r_done;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_in;

    logic              w_edge;
    logic [ADDR_W-1:0] w_addr_next;
    logic [ADDR_W:0]   w_count_next;

`ifdef PROGRAM_LOADER_VERIFY_EN
    logic [DATA_W-1:0] r_chk;
    logic [DATA_W-1:0] r_vsum;
    logic [ADDR_W:0]   r_vcnt;
    logic              r_error;
`endif

    // Rising edge of the synchronised Enter level; holding the button
    // therefore yields a single one-cycle pulse.
    assign w_edge       = r_s2 & ~r_d;
    assign w_addr_next  = r_addr + 1'b1;
    assign w_count_next = (r_count == c_FULL) ? r_count : r_count + 1'b1;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state    <= c_S_IDLE;
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_d        <= 1'b0;
            r_addr     <= '0;
            r_count    <= '0;
            r_fin      <= 1'b0;
            r_busy     <= 1'b0;
            r_wr       <= 1'b0;
            r_done     <= 1'b0;
            r_ram_addr <= '0;
            r_ram_in   <= '0;
`ifdef PROGRAM_LOADER_VERIFY_EN
            r_chk      <= '0;
            r_vsum     <= '0;
            r_vcnt     <= '0;
            r_error    <= 1'b0;
`endif
        end else begin
            r_s1 <= Enter;
            r_s2 <= r_s1;
            r_d  <= r_s2;
            // Write strobe is re-armed only by the transitions that need it.
            r_wr <= 1'b0;

            case (r_state)
                c_S_IDLE, c_S_DONE: begin
                    if (Start) begin
                        r_state <= c_S_LOAD;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_count <= '0;
                        r_addr  <= '0;
                        r_fin   <= 1'b0;
`ifdef PROGRAM_LOADER_VERIFY_EN
                        r_chk   <= '0;
                        r_error <= 1'b0;
`endif
                    end
                end

                c_S_LOAD: begin
                    if (w_edge) begin
                        r_state    <= c_S_WRITE;
                        r_ram_in   <= Input;
                        r_ram_addr <= r_addr;
                        r_wr       <= 1'b1;
                        // Finish coinciding with a press: write it, then pad.
                        r_fin      <= Finish;
                    end else if (Finish) begin
                        r_state    <= c_S_FILL;
                        r_ram_in   <= FILL_VALUE;
                        r_ram_addr <= r_addr;
                        r_wr       <= 1'b1;
                    end
                end

                c_S_WRITE: begin
                    r_addr  <= w_addr_next;
                    r_count <= w_count_next;
`ifdef PROGRAM_LOADER_VERIFY_EN
                    r_chk   <= r_chk + r_ram_in;
`endif
                    if (r_addr == c_LAST) begin
`ifdef PROGRAM_LOADER_VERIFY_EN
                        r_state    <= c_S_VERIFY;
                        r_ram_addr <= w_addr_next;
                        r_vcnt     <= '0;
                        r_vsum     <= '0;
`else
                        r_state    <= c_S_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
`endif
                    end else if (r_fin) begin
                        r_state    <= c_S_FILL;
                        r_ram_in   <= FILL_VALUE;
                        r_ram_addr <= w_addr_next;
                        r_wr       <= 1'b1;
                    end else begin
                        r_state    <= c_S_LOAD;
                    end
                end

                // r_addr and r_ram_addr advance together here.
                c_S_FILL: begin
                    r_addr <= w_addr_next;
`ifdef PROGRAM_LOADER_VERIFY_EN
                    r_chk  <= r_chk + r_ram_in;
`endif
                    if (r_addr == c_LAST) begin
`ifdef PROGRAM_LOADER_VERIFY_EN
                        r_state    <= c_S_VERIFY;
                        r_ram_addr <= w_addr_next;
                        r_vcnt     <= '0;
                        r_vsum     <= '0;
`else
                        r_state    <= c_S_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
`endif
                    end else begin
                        r_ram_addr <= w_addr_next;
                        r_wr       <= 1'b1;
                    end
                end

`ifdef PROGRAM_LOADER_VERIFY_EN
                // Cycle n presents address n; RamOut then carries word n-1,
                // so the sweep spans DEPTH+1 cycles and the last word is
                // folded into the comparison directly.
                c_S_VERIFY: begin
                    r_vcnt     <= r_vcnt + 1'b1;
                    r_ram_addr <= r_ram_addr + 1'b1;
                    if (r_vcnt != '0) begin
                        r_vsum <= r_vsum + RamOut;
                    end
                    if (r_vcnt == c_FULL) begin
                        r_error <= ((r_vsum + RamOut) != r_chk);
                        r_state <= c_S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
`endif

                default: begin
                    r_state <= c_S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign RamInit    = r_busy;
    assign CpuHold    = r_busy;
    assign Busy       = r_busy;
    assign RamWr      = r_wr;
    assign RamAddress = r_ram_addr;
    assign RamIn      = r_ram_in;
    assign Done       = r_done;
    assign Count      = r_count;
    assign state      = r_state;

`ifdef PROGRAM_LOADER_VERIFY_EN
    assign Error = r_error;
`else
    // Read data is only consumed by the verify pass.
    logic w_unused_ramout;
    assign w_unused_ramout = ^RamOut;
    assign Error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. Randomised byte
//               streams are checked against an expected RAM image built from
//               the session rules (user bytes first, pad value after).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int         DEPTH = 32;
    localparam logic [7:0] FILL  = 8'hE0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_VERIFY = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic       Clock  = 1'b0;
    logic       Reset  = 1'b0;
    logic       Start  = 1'b0;
    logic       Enter  = 1'b0;
    logic       Finish = 1'b0;
    logic [7:0] Input  = 8'h00;
    logic [7:0] RamOut;
    logic       RamInit, RamWr, CpuHold, Busy, Done, Error;
    logic [4:0] RamAddress;
    logic [7:0] RamIn;
    logic [5:0] Count;
    logic [2:0] state;

    program_loader dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Enter(Enter),
        .Input(Input), .Finish(Finish), .RamOut(RamOut),
        .RamInit(RamInit), .RamAddress(RamAddress), .RamIn(RamIn),
        .RamWr(RamWr), .CpuHold(CpuHold), .Busy(Busy), .Done(Done),
        .Error(Error), .Count(Count), .state(state)
    );

    always #5 Clock = ~Clock;

    // Behavioural synchronous RAM, with an optional one-shot corruption of
    // location 7 once the read-back pass has begun.
    logic [7:0] mem [DEPTH];
    bit corrupt_arm  = 1'b0;
    bit corrupt_done = 1'b0;
    always @(posedge Clock) begin
        if (RamWr) mem[RamAddress] <= RamIn;
        RamOut <= mem[RamAddress];
        if (!corrupt_arm) corrupt_done <= 1'b0;
        else if (!corrupt_done && state == S_VERIFY) begin
            mem[7]       <= ~mem[7];
            corrupt_done <= 1'b1;
        end
    end

    // Activity counters sampled mid-cycle.
    int user_wr = 0, fill_wr = 0, ver_cyc = 0, run = 0, last_run = 0;
    always @(negedge Clock) begin
        if (RamWr && state == S_WRITE) user_wr <= user_wr + 1;
        if (RamWr && state == 3'd3)    fill_wr <= fill_wr + 1;
        if (state == S_VERIFY)         ver_cyc <= ver_cyc + 1;
        if (RamWr) run <= run + 1;
        else begin
            run <= 0;
            if (run != 0) last_run <= run;
        end
    end

    int n_vec = 0, n_miss = 0;
    int u0, f0, v0;
    logic [7:0] bytes_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int k = 0;
        while (state !== s && k < budget) begin
            @(negedge Clock);
            k++;
        end
        chk({tag, "_reach"}, 32'(state), 32'(s));
    endtask

    task automatic start_session(input string tag);
        bytes_q.delete();
        u0 = user_wr; f0 = fill_wr; v0 = ver_cyc;
        @(negedge Clock) Start = 1'b1;
        @(negedge Clock) Start = 1'b0;
        chk({tag, "_st_state"}, 32'(state), 32'(S_LOAD));
        chk({tag, "_st_flags"}, {26'd0, RamInit, CpuHold, Busy, Done, Error, RamWr}, 32'b111000);
        chk({tag, "_st_count"}, 32'(Count), 32'd0);
    endtask

    task automatic press(input logic [7:0] b, input int hold, input int gap);
        @(negedge Clock);
        Input = b;
        Enter = 1'b1;
        bytes_q.push_back(b);
        repeat (hold) @(negedge Clock);
        Enter = 1'b0;
        repeat (gap) @(negedge Clock);
    endtask

    task automatic finish_pulse();
        repeat (4) @(negedge Clock);
        Finish = 1'b1;
        @(negedge Clock) Finish = 1'b0;
    endtask

    task automatic end_session(input string tag, input int n, input bit corrupt, input bit check_mem);
        bit exp_err;
        logic [7:0] exp;
`ifdef PROGRAM_LOADER_VERIFY_EN
        exp_err = corrupt;
`else
        exp_err = 1'b0;
`endif
        wait_state(S_DONE, 300, tag);
        @(negedge Clock);
        chk({tag, "_count"}, 32'(Count), 32'(n));
        chk({tag, "_flags"}, {26'd0, RamInit, CpuHold, Busy, Done, Error, RamWr},
            {26'd0, 3'b000, 1'b1, exp_err, 1'b0});
        chk({tag, "_user_wr"}, 32'(user_wr - u0), 32'(n));
        chk({tag, "_fill_wr"}, 32'(fill_wr - f0), 32'(DEPTH - n));
`ifdef PROGRAM_LOADER_VERIFY_EN
        chk({tag, "_verify_cyc"}, 32'(ver_cyc - v0), 32'(DEPTH + 1));
`else
        chk({tag, "_verify_cyc"}, 32'(ver_cyc - v0), 32'd0);
`endif
        if (check_mem) begin
            for (int i = 0; i < DEPTH; i++) begin
                exp = (i < n) ? bytes_q[i] : FILL;
                chk($sformatf("%s_mem%0d", tag, i), 32'(mem[i]), 32'(exp));
            end
        end
    endtask

    initial begin
        int n;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge Clock);
        chk("rst_flags", {26'd0, RamInit, CpuHold, Busy, Done, Error, RamWr}, 32'd0);
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_addr_data", {19'd0, RamAddress, RamIn}, 32'd0);
        chk("rst_count", 32'(Count), 32'd0);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);

        // Full load of 0x01..0x20, no padding
        start_session("full");
        for (int i = 1; i <= DEPTH; i++)
            press(8'(i), 1 + int'($urandom_range(2)), 2 + int'($urandom_range(2)));
        end_session("full", DEPTH, 1'b0, 1'b1);
        chk("full_single_pulse", 32'(last_run), 32'd1);

        // Three bytes then Finish: 29 consecutive pad writes
        start_session("three");
        press(8'hA1, 2, 3);
        press(8'hA2, 1, 2);
        press(8'hA3, 3, 2);
        finish_pulse();
        end_session("three", 3, 1'b0, 1'b1);
        chk("three_fill_run", 32'(last_run), 32'd29);

        // Long hold, write latency and Start ignored in LOAD
        start_session("hold");
        b = 8'($urandom);
        @(negedge Clock);
        Input = b;
        Enter = 1'b1;
        bytes_q.push_back(b);
        @(negedge Clock);
        chk("lat_k1", 32'(RamWr), 32'd0);
        @(negedge Clock);
        chk("lat_k2", 32'(RamWr), 32'd0);
        @(negedge Clock);
        chk("lat_k3_wr", {23'd0, RamWr, RamIn}, {23'd0, 1'b1, b});
        chk("lat_k3_addr", 32'(RamAddress), 32'd0);
        @(negedge Clock) Start = 1'b1;
        @(negedge Clock) Start = 1'b0;
        chk("start_in_load", 32'(state), 32'(S_LOAD));
        repeat (95) @(negedge Clock);
        chk("hold_one_write", 32'(Count), 32'd1);
        Enter = 1'b0;
        repeat (3) @(negedge Clock);
        n = 2 + int'($urandom_range(18));
        for (int i = 1; i < n; i++)
            press(8'($urandom), 1 + int'($urandom_range(3)), 2 + int'($urandom_range(3)));
        finish_pulse();
        end_session("hold", n, 1'b0, 1'b1);
        chk("hold_fill_run", 32'(last_run), 32'(DEPTH - n));

        // Finish and Enter edge in the same cycle
        start_session("coinc");
        n = int'($urandom_range(10));
        for (int i = 0; i < n; i++)
            press(8'($urandom), 1 + int'($urandom_range(2)), 2 + int'($urandom_range(2)));
        @(negedge Clock);
        Input = 8'h55;
        Enter = 1'b1;
        bytes_q.push_back(8'h55);
        @(negedge Clock);
        @(negedge Clock) Finish = 1'b1;
        @(negedge Clock) Finish = 1'b0;
        chk("coinc_wr", {21'd0, state, RamWr, RamIn}, {21'd0, S_WRITE, 1'b1, 8'h55});
        chk("coinc_addr", 32'(RamAddress), 32'(n));
        @(negedge Clock) Enter = 1'b0;
        end_session("coinc", n + 1, 1'b0, 1'b1);
        chk("coinc_run", 32'(last_run), 32'(DEPTH - n));

        // Corrupted read-back
        corrupt_arm = 1'b1;
        start_session("corrupt");
        for (int i = 0; i < 5; i++)
            press(8'($urandom), 1, 2 + int'($urandom_range(2)));
        finish_pulse();
        end_session("corrupt", 5, 1'b1, 1'b0);
        corrupt_arm = 1'b0;

        // Reset mid-LOAD after three writes (Start also clears Error)
        start_session("abort");
        for (int i = 0; i < 3; i++)
            press(8'($urandom), 1, 2);
        repeat (4) @(negedge Clock);
        chk("abort_count", 32'(Count), 32'd3);
        Reset = 1'b0;
        @(negedge Clock);
        chk("abort_flags", {26'd0, RamInit, CpuHold, Busy, Done, Error, RamWr}, 32'd0);
        chk("abort_state", 32'(state), 32'(S_IDLE));
        chk("abort_regs", {13'd0, Count, RamAddress, RamIn}, 32'd0);
        Reset = 1'b1;
        @(negedge Clock);

        // Immediate Finish: whole RAM padded
        start_session("empty");
        finish_pulse();
        end_session("empty", 0, 1'b0, 1'b1);
        chk("empty_run", 32'(last_run), 32'(DEPTH));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
